// File: rtl/core_link_fifo.sv
// core_link_fifo: buffered one-way word channel between two RISC621 cores.
// Sender side uses a bit-0 toggle request/acknowledge pair; receiver side is
// presented one registered word at a time with its own bit-0 toggle pair.
// Upper bits of the two handshake outputs carry free-slot / occupancy status.
module core_link_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             Clock_pin,
    input  logic             Resetn_pin,
    input  logic [WIDTH-1:0] tx_req_in,
    input  logic [WIDTH-1:0] tx_data_in,
    output logic [WIDTH-1:0] tx_ack_out,
    output logic [WIDTH-1:0] rx_req_out,
    output logic [WIDTH-1:0] rx_data_out,
    input  logic [WIDTH-1:0] rx_ack_in
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_WAIT = 1'b1
    } rx_state_t;

    // Storage and pointers
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      r_free;

    // Handshake state
    logic             r_req_seen;
    logic             r_ack_tgl;
    logic             r_rx_tgl;
    logic [WIDTH-1:0] r_rx_data;
    rx_state_t        r_state;

    // Combinational control
    rx_state_t        w_state_next;
    logic             w_new_req;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_next;

    // Only bit 0 of the request/ack inputs carries meaning; the rest is
    // software-owned and deliberately ignored.
    logic             w_unused_bits;
    assign w_unused_bits = ^{tx_req_in[WIDTH-1:1], rx_ack_in[WIDTH-1:1]};

    // Push decision: a differing request bit is a new word; it is taken only
    // when the pre-pop count leaves room, otherwise it stays pending.
    always_comb begin
        w_new_req = tx_req_in[0] ^ r_req_seen;
        w_push    = w_new_req && (r_count < DEPTH_C);
    end

    // Receive FSM next-state and pop strobe
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (rx_ack_in[0] == r_rx_tgl) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Word storage; contents are don't-care while pointers say empty
    always_ff @(posedge Clock_pin) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_in;
        end
    end

    // Sender-side state: write pointer, seen request bit, ack toggle
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_wr_ptr   <= '0;
            r_req_seen <= 1'b0;
            r_ack_tgl  <= 1'b0;
        end else if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_req_seen <= tx_req_in[0];
            r_ack_tgl  <= ~r_ack_tgl;
        end
    end

    // Receiver-side state: FSM register, read pointer, presented word, toggle
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_state   <= RX_IDLE;
            r_rd_ptr  <= '0;
            r_rx_data <= '0;
            r_rx_tgl  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_rx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rx_tgl  <= ~r_rx_tgl;
            end
        end
    end

    // Registered status, updated on the same edge as the pointers
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_count <= '0;
            r_free  <= DEPTH_C;
        end else begin
            r_count <= w_count_next;
            r_free  <= DEPTH_C - w_count_next;
        end
    end

    // Pack status fields above the toggle bits
    always_comb begin
        tx_ack_out         = '0;
        tx_ack_out[AW+1:1] = r_free;
        tx_ack_out[0]      = r_ack_tgl;
        rx_req_out         = '0;
        rx_req_out[AW+1:1] = r_count;
        rx_req_out[0]      = r_rx_tgl;
    end

    assign rx_data_out = r_rx_data;

    // Occupancy never exceeds capacity and status fields stay complementary
    a_count_range : assert property (@(posedge Clock_pin) disable iff (!Resetn_pin)
        r_count <= DEPTH_C);
    a_status_sum : assert property (@(posedge Clock_pin) disable iff (!Resetn_pin)
        (r_free + r_count) == DEPTH_C);

endmodule

// File: tb/tb_core_link_fifo.sv
// Self-checking bench for core_link_fifo: sender/receiver toggle handshakes,
// full-boundary holding, ordering across pointer wrap, and reset behaviour.
module tb_core_link_fifo;

    localparam int WIDTH = 14;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  tx_req_in;
    logic [WIDTH-1:0]  tx_data_in;
    logic [WIDTH-1:0]  tx_ack_out;
    logic [WIDTH-1:0]  rx_req_out;
    logic [WIDTH-1:0]  rx_data_out;
    logic [WIDTH-1:0]  rx_ack_in;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [WIDTH-1:0]  q_exp[$];
    logic              tx_bit = 1'b0;
    logic              rx_bit = 1'b0;

    always #5 clk = ~clk;

    core_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .tx_req_in   (tx_req_in),
        .tx_data_in  (tx_data_in),
        .tx_ack_out  (tx_ack_out),
        .rx_req_out  (rx_req_out),
        .rx_data_out (rx_data_out),
        .rx_ack_in   (rx_ack_in)
    );

    // Stimulus helpers (no checking): all driving happens on the falling edge
    task automatic drive_word(input logic [WIDTH-1:0] d);
        tx_data_in = d;
        tx_bit     = ~tx_bit;
        tx_req_in  = {13'b0, tx_bit};
        q_exp.push_back(d);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tx_ack_out[0] == tx_bit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rx(output bit ok, output logic [WIDTH-1:0] d);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rx_req_out[0] != rx_bit) begin
                ok = 1'b1;
                d  = rx_data_out;
                break;
            end
        end
    endtask

    task automatic ack_rx();
        rx_bit    = ~rx_bit;
        rx_ack_in = {13'b0, rx_bit};
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp_d;
        rst_n = 1'b0;
        tx_req_in = '0; tx_data_in = '0; rx_ack_in = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx_ack_out !== 14'h0010) begin n_fail++; $display("FAIL reset_ack: got %h expected %h", tx_ack_out, 14'h0010); end
        n_tests++;
        if (rx_req_out !== 14'h0000) begin n_fail++; $display("FAIL reset_rxreq: got %h expected %h", rx_req_out, 14'h0000); end
        n_tests++;
        if (rx_data_out !== 14'h0000) begin n_fail++; $display("FAIL reset_rxdata: got %h expected %h", rx_data_out, 14'h0000); end
        rst_n = 1'b1;
        @(negedge clk);
        drive_word(14'h0555);
        repeat (3) @(negedge clk);
        exp_d = q_exp.pop_front();
        n_tests++;
        if (rx_data_out !== exp_d) begin n_fail++; $display("FAIL pre_reset_word: got %h expected %h", rx_data_out, exp_d); end
        #2;
        rst_n = 1'b0;
        tx_req_in = '0; rx_ack_in = '0; tx_bit = 1'b0; rx_bit = 1'b0;
        q_exp.delete();
        #1;
        n_tests++;
        if (tx_ack_out !== 14'h0010) begin n_fail++; $display("FAIL async_reset_ack: got %h expected %h", tx_ack_out, 14'h0010); end
        n_tests++;
        if (rx_req_out !== 14'h0000) begin n_fail++; $display("FAIL async_reset_rxreq: got %h expected %h", rx_req_out, 14'h0000); end
        n_tests++;
        if (rx_data_out !== 14'h0000) begin n_fail++; $display("FAIL async_reset_rxdata: got %h expected %h", rx_data_out, 14'h0000); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] exp_d;
        drive_word(14'h1ABC);
        @(negedge clk);
        n_tests++;
        if (tx_ack_out !== 14'h000F) begin n_fail++; $display("FAIL single_ack: got %h expected %h", tx_ack_out, 14'h000F); end
        n_tests++;
        if (rx_req_out !== 14'h0002) begin n_fail++; $display("FAIL single_occ: got %h expected %h", rx_req_out, 14'h0002); end
        @(negedge clk);
        exp_d = q_exp.pop_front();
        n_tests++;
        if (rx_data_out !== exp_d) begin n_fail++; $display("FAIL single_data: got %h expected %h", rx_data_out, exp_d); end
        n_tests++;
        if (rx_req_out !== 14'h0001) begin n_fail++; $display("FAIL single_rxreq: got %h expected %h", rx_req_out, 14'h0001); end
        n_tests++;
        if (tx_ack_out !== 14'h0011) begin n_fail++; $display("FAIL single_free: got %h expected %h", tx_ack_out, 14'h0011); end
        ack_rx();
        repeat (2) @(negedge clk);
        n_tests++;
        if (rx_req_out !== 14'h0001) begin n_fail++; $display("FAIL single_idle_hold: got %h expected %h", rx_req_out, 14'h0001); end
        // a fresh word presented two edges after its toggle shows the FSM is idle again
        drive_word(14'h0123);
        repeat (2) @(negedge clk);
        exp_d = q_exp.pop_front();
        n_tests++;
        if (rx_data_out !== exp_d) begin n_fail++; $display("FAIL single_second_data: got %h expected %h", rx_data_out, exp_d); end
        n_tests++;
        if (rx_req_out !== {13'd0, ~rx_bit}) begin n_fail++; $display("FAIL single_second_rxreq: got %h expected %h", rx_req_out, {13'd0, ~rx_bit}); end
        ack_rx();
        repeat (2) @(negedge clk);
    endtask

    // First word is popped into the output register, so eight more fill the
    // buffer and the tenth request is the one held at the full boundary.
    task automatic test_fill();
        bit ok;
        logic [WIDTH-1:0] exp_d;
        for (int i = 1; i <= 9; i++) begin
            drive_word(14'(i));
            wait_ack(ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL fill_ack_%0d: got timeout expected ack", i); end
        end
        exp_d = q_exp.pop_front();
        n_tests++;
        if (rx_data_out !== exp_d) begin n_fail++; $display("FAIL fill_first: got %h expected %h", rx_data_out, exp_d); end
        n_tests++;
        if (tx_ack_out[13:1] !== 13'd0) begin n_fail++; $display("FAIL fill_free: got %0d expected 0", tx_ack_out[13:1]); end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd8) begin n_fail++; $display("FAIL fill_occ: got %0d expected 8", rx_req_out[13:1]); end
        drive_word(14'h000A);
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx_ack_out[0] !== ~tx_bit) begin n_fail++; $display("FAIL fill_held: got %b expected %b", tx_ack_out[0], ~tx_bit); end
        ack_rx();
        @(negedge clk);
        n_tests++;
        if (tx_ack_out[0] !== ~tx_bit) begin n_fail++; $display("FAIL fill_held_after_ack: got %b expected %b", tx_ack_out[0], ~tx_bit); end
        @(negedge clk);
        exp_d = q_exp.pop_front();
        n_tests++;
        if (rx_data_out !== exp_d) begin n_fail++; $display("FAIL fill_second: got %h expected %h", rx_data_out, exp_d); end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd7) begin n_fail++; $display("FAIL fill_pop_occ: got %0d expected 7", rx_req_out[13:1]); end
        n_tests++;
        if (tx_ack_out[0] !== ~tx_bit) begin n_fail++; $display("FAIL fill_held_at_pop: got %b expected %b", tx_ack_out[0], ~tx_bit); end
        @(negedge clk);
        n_tests++;
        if (tx_ack_out !== {13'd0, tx_bit}) begin n_fail++; $display("FAIL fill_accept: got %h expected %h", tx_ack_out, {13'd0, tx_bit}); end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd8) begin n_fail++; $display("FAIL fill_refull: got %0d expected 8", rx_req_out[13:1]); end
    endtask

    task automatic test_full_collision();
        bit ok;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_d;
        drive_word(14'h000B);
        ack_rx();
        @(negedge clk);
        n_tests++;
        if (tx_ack_out[0] !== ~tx_bit) begin n_fail++; $display("FAIL coll_held: got %b expected %b", tx_ack_out[0], ~tx_bit); end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd8) begin n_fail++; $display("FAIL coll_occ_a: got %0d expected 8", rx_req_out[13:1]); end
        @(negedge clk);
        n_tests++;
        if (rx_req_out[13:1] !== 13'd7) begin n_fail++; $display("FAIL coll_pop_occ: got %0d expected 7", rx_req_out[13:1]); end
        exp_d = q_exp.pop_front();
        n_tests++;
        if (rx_data_out !== exp_d) begin n_fail++; $display("FAIL coll_pop_data: got %h expected %h", rx_data_out, exp_d); end
        n_tests++;
        if (tx_ack_out[0] !== ~tx_bit) begin n_fail++; $display("FAIL coll_held_at_pop: got %b expected %b", tx_ack_out[0], ~tx_bit); end
        @(negedge clk);
        n_tests++;
        if (tx_ack_out !== {13'd0, tx_bit}) begin n_fail++; $display("FAIL coll_push: got %h expected %h", tx_ack_out, {13'd0, tx_bit}); end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd8) begin n_fail++; $display("FAIL coll_refull: got %0d expected 8", rx_req_out[13:1]); end
        ack_rx();
        while (q_exp.size() != 0) begin
            wait_rx(ok, d);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL drain_timeout: got timeout expected word %h", q_exp[0]);
                q_exp.delete();
            end else begin
                exp_d = q_exp.pop_front();
                if (d !== exp_d) begin n_fail++; $display("FAIL drain_data: got %h expected %h", d, exp_d); end
                ack_rx();
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx_ack_out[13:1] !== 13'd8) begin n_fail++; $display("FAIL drain_free: got %0d expected 8", tx_ack_out[13:1]); end
        n_tests++;
        if (rx_req_out !== {13'd0, rx_bit}) begin n_fail++; $display("FAIL drain_empty: got %h expected %h", rx_req_out, {13'd0, rx_bit}); end
    endtask

    task automatic test_stream();
        fork
            begin : sender
                bit ok;
                for (int i = 0; i < 20; i++) begin
                    drive_word(14'h3FF0 + 14'(i));
                    wait_ack(ok);
                    n_tests++;
                    if (!ok) begin n_fail++; $display("FAIL stream_ack_%0d: got timeout expected ack", i); end
                end
            end
            begin : receiver
                bit ok;
                logic [WIDTH-1:0] d;
                logic [WIDTH-1:0] exp_d;
                for (int j = 0; j < 20; j++) begin
                    wait_rx(ok, d);
                    n_tests++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL stream_rx_%0d: got timeout expected word", j);
                        break;
                    end
                    if (q_exp.size() == 0) begin
                        n_fail++;
                        $display("FAIL stream_extra: got %h expected no word", d);
                    end else begin
                        exp_d = q_exp.pop_front();
                        if (d !== exp_d) begin n_fail++; $display("FAIL stream_data_%0d: got %h expected %h", j, d, exp_d); end
                    end
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    ack_rx();
                end
            end
        join
        repeat (4) @(negedge clk);
        n_tests++;
        if (q_exp.size() != 0) begin n_fail++; $display("FAIL stream_leftover: got %0d expected 0", q_exp.size()); end
        n_tests++;
        if (rx_req_out !== {13'd0, rx_bit}) begin n_fail++; $display("FAIL stream_dup: got %h expected %h", rx_req_out, {13'd0, rx_bit}); end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_d;
        for (int i = 0; i < 6; i++) begin
            drive_word(14'h0100 + 14'(i));
            wait_ack(ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL mid_ack_%0d: got timeout expected ack", i); end
        end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd5) begin n_fail++; $display("FAIL mid_occ: got %0d expected 5", rx_req_out[13:1]); end
        #2;
        rst_n = 1'b0;
        tx_req_in = '0; rx_ack_in = '0; tx_bit = 1'b0; rx_bit = 1'b0;
        q_exp.delete();
        #1;
        n_tests++;
        if (tx_ack_out !== 14'h0010) begin n_fail++; $display("FAIL mid_reset_ack: got %h expected %h", tx_ack_out, 14'h0010); end
        n_tests++;
        if (rx_data_out !== 14'h0000) begin n_fail++; $display("FAIL mid_reset_data: got %h expected %h", rx_data_out, 14'h0000); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (tx_ack_out !== 14'h0010) begin n_fail++; $display("FAIL post_reset_free: got %h expected %h", tx_ack_out, 14'h0010); end
        n_tests++;
        if (rx_req_out !== 14'h0000) begin n_fail++; $display("FAIL post_reset_empty: got %h expected %h", rx_req_out, 14'h0000); end
        drive_word(14'h2222);
        wait_ack(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL post_reset_ack: got timeout expected ack"); end
        wait_rx(ok, d);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL post_reset_rx: got timeout expected word");
        end else begin
            exp_d = q_exp.pop_front();
            if (d !== exp_d) begin n_fail++; $display("FAIL post_reset_data: got %h expected %h", d, exp_d); end
        end
        n_tests++;
        if (rx_req_out[13:1] !== 13'd0) begin n_fail++; $display("FAIL post_reset_occ: got %0d expected 0", rx_req_out[13:1]); end
        ack_rx();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_collision();
        test_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
